muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution stage beside the register file.
- Consumes rs1/rs2 operand data read from the register file.
- Produces a write-back result (data, address, write enable) that drives the register-file write port.
- The core holds `busy_o` as a stall while an operation is in flight; one operation at a time, no queueing.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_core.sv | 70 +++++++
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, op encoding and FSM states
// for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: radix-2 shift-add / restoring shift-subtract datapath.
// Ports: clk_i, rst_ni, i_load, i_step, i_div, i_a, i_b -> o_hi, o_lo, o_last.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo,
  output logic            o_last
);

  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_b;
  logic             r_div;
  logic [CNT_W-1:0] r_cnt;

  logic [XLEN:0]    w_sum;
  logic [XLEN:0]    w_sh;
  logic             w_ge;
  logic [XLEN-1:0]  w_diff;

  // multiply: {hi,lo} shifts right, lo[0] picks the addend
  assign w_sum = {1'b0, r_hi}
               + (r_lo[0] ? {1'b0, r_b} : '0);

  // divide: hi is the partial remainder, lo shifts
  // dividend bits out and quotient bits in
  assign w_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_ge   = (w_sh >= {1'b0, r_b});
  assign w_diff = w_sh[XLEN-1:0] - r_b;

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_last = (r_cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_div <= i_div;
      r_cnt <= '0;
      r_lo  <= i_div ? i_a : i_b;
      r_b   <= i_div ? i_b : i_a;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_div) begin
        r_hi <= w_ge ? w_diff : w_sh[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_ge};
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M mul/div stage, FSM IDLE/CALC/FIX/DONE driving rd write-back.
// Ports: start_i/op_i/rs1/rs2/rd_addr_i/kill_i in; busy_o/done_o/rd_* out. Option: MULDIV_FAST_MUL_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            rd_wren_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o
);

  logic [1:0]        r_state;
  logic [2:0]        r_op;
  logic [4:0]        r_rd_addr;
  logic [4:0]        r_rd_addr_o;
  logic [XLEN-1:0]   r_rd_data;
  logic              r_neg_q;
  logic              r_neg_r;

  logic              w_a_sgn;
  logic              w_b_sgn;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_res;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_launch;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_f;
  logic [XLEN-1:0]   w_quot_f;
  logic [XLEN-1:0]   w_rem_f;
  logic [XLEN-1:0]   w_res;

  assign w_a_sgn = (op_i == MD_MULH) | (op_i == MD_MULHSU)
                 | (op_i == MD_DIV)  | (op_i == MD_REM);
  assign w_b_sgn = (op_i == MD_MULH) | (op_i == MD_DIV)
                 | (op_i == MD_REM);
  assign w_a_neg = w_a_sgn & rs1_data_i[XLEN-1];
  assign w_b_neg = w_b_sgn & rs2_data_i[XLEN-1];
  assign w_abs_a = w_a_neg ? -rs1_data_i : rs1_data_i;
  assign w_abs_b = w_b_neg ? -rs2_data_i : rs2_data_i;

  assign w_div0 = op_i[2] & (rs2_data_i == '0);
  assign w_ovf  = ((op_i == MD_DIV) | (op_i == MD_REM))
                & (rs1_data_i == INT_MIN)
                & (rs2_data_i == DIV0_QUOT);
  assign w_special = w_div0 | w_ovf;

  // op_i[1] separates REM/REMU from DIV/DIVU
  assign w_spec_res = w_div0 ? (op_i[1] ? rs1_data_i : DIV0_QUOT)
                             : (op_i[1] ? '0 : INT_MIN);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa;
  logic signed [XLEN:0]     w_fb;
  logic signed [2*XLEN+1:0] w_fp;

  // a 33-bit signed product covers every signedness mix
  assign w_fa = {w_a_sgn & rs1_data_i[XLEN-1], rs1_data_i};
  assign w_fb = {w_b_sgn & rs2_data_i[XLEN-1], rs2_data_i};
  assign w_fp = w_fa * w_fb;
  assign w_fast = !op_i[2];
  assign w_fast_res = (op_i == MD_MUL) ? w_fp[XLEN-1:0]
                                       : w_fp[2*XLEN-1:XLEN];
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  assign w_launch = (r_state == ST_IDLE) & start_i & !kill_i;
  assign w_load   = w_launch & !w_special & !w_fast;
  assign w_step   = (r_state == ST_CALC) & !kill_i;

  muldiv_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_load (w_load),
    .i_step (w_step),
    .i_div  (op_i[2]),
    .i_a    (w_abs_a),
    .i_b    (w_abs_b),
    .o_hi   (w_hi),
    .o_lo   (w_lo),
    .o_last (w_last)
  );

  assign w_prod   = {w_hi, w_lo};
  assign w_prod_f = r_neg_q ? -w_prod : w_prod;
  assign w_quot_f = r_neg_q ? -w_lo : w_lo;
  assign w_rem_f  = r_neg_r ? -w_hi : w_hi;

  always_comb begin
    w_res = w_quot_f;
    unique case (1'b1)
      (r_op == MD_MUL):
        w_res = w_prod_f[XLEN-1:0];
      (!r_op[2] && (r_op != MD_MUL)):
        w_res = w_prod_f[2*XLEN-1:XLEN];
      (r_op[2] && r_op[1]):
        w_res = w_rem_f;
      (r_op[2] && !r_op[1]):
        w_res = w_quot_f;
      default:
        w_res = w_quot_f;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_rd_addr   <= '0;
      r_rd_addr_o <= '0;
      r_rd_data   <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_op      <= op_i;
            r_rd_addr <= rd_addr_i;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            if (w_special) begin
              r_rd_data   <= w_spec_res;
              r_rd_addr_o <= rd_addr_i;
              r_state     <= ST_DONE;
            end else if (w_fast) begin
              r_rd_data   <= w_fast_res;
              r_rd_addr_o <= rd_addr_i;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (kill_i) r_state <= ST_IDLE;
          else if (w_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (kill_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_rd_data   <= w_res;
            r_rd_addr_o <= r_rd_addr;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = (r_state != ST_IDLE);
  assign done_o    = (r_state == ST_DONE);
  // a flush landing on the DONE cycle must still block the write
  assign rd_wren_o = done_o & (r_rd_addr_o != '0) & !kill_i;
  assign rd_addr_o = r_rd_addr_o;
  assign rd_data_o = r_rd_data;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors plus a cycle-level reference model
// of muldiv_unit, compared on every falling clock edge.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        kill  = 1'b0;
  logic [2:0]  op    = '0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic [4:0]  rd    = '0;

  logic        busy;
  logic        done;
  logic        wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .op_i       (op),
    .rs1_data_i (a),
    .rs2_data_i (b),
    .rd_addr_i  (rd),
    .kill_i     (kill),
    .busy_o     (busy),
    .done_o     (done),
    .rd_wren_o  (wren),
    .rd_addr_o  (rd_addr),
    .rd_data_o  (rd_data)
  );

  function automatic logic [31:0] ref_res(
    input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    logic ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'({32'd0, x});
    uy  = longint'({32'd0, y});
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      OP_MUL:    begin p = 64'(ux * uy); return p[31:0]; end
      OP_MULH:   begin p = 64'(sx * sy); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
      OP_MULHU:  begin p = 64'(ux * uy); return p[63:32]; end
      OP_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sx / sy);
      end
      OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REM: begin
        if (y == 0) return x;
        if (ovf) return 32'd0;
        return 32'(sx % sy);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_of(
    input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic ovf;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF) && !o[0];
    if (!o[2]) return MUL_LAT;
    if ((y == 0) || ovf) return 1;
    return 34;
  endfunction

  // cycle model: m_cyc counts cycles since launch, 0 = idle
  int          m_cyc = 0;
  int          m_lat = 0;
  logic [31:0] m_pend = '0;
  logic [4:0]  m_pend_a = '0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_addr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      m_lat  <= 0;
      m_data <= '0;
      m_addr <= '0;
    end else if (m_cyc != 0) begin
      if (kill || m_cyc == m_lat) begin
        m_cyc <= 0;
      end else begin
        m_cyc <= m_cyc + 1;
        if (m_cyc + 1 == m_lat) begin
          m_data <= m_pend;
          m_addr <= m_pend_a;
        end
      end
    end else if (start && !kill) begin
      m_lat    <= lat_of(op, a, b);
      m_pend   <= ref_res(op, a, b);
      m_pend_a <= rd;
      m_cyc    <= 1;
      if (lat_of(op, a, b) == 1) begin
        m_data <= ref_res(op, a, b);
        m_addr <= rd;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_busy", 32'(busy), 32'(m_cyc != 0));
      chk("m_done", 32'(done), 32'(m_cyc != 0 && m_cyc == m_lat));
      chk("m_wren", 32'(wren),
          32'(m_cyc != 0 && m_cyc == m_lat && m_addr != 0 && !kill));
      chk("m_rd_addr", 32'(rd_addr), 32'(m_addr));
      chk("m_rd_data", rd_data, m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] r);
    @(posedge clk);
    #2;
    op = o; a = x; b = y; rd = r; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input string nm, input logic [31:0] lit,
                           input int lat, input bit exp_w);
    bit got;
    got = 1'b0;
    while (!got && cyc <= 100) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk({nm, "_lat"}, 32'(cyc), 32'(lat));
        chk({nm, "_data"}, rd_data, lit);
        chk({nm, "_wren"}, 32'(wren), 32'(exp_w));
      end else begin
        tick();
      end
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  task automatic run(input string nm, input logic [2:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] r, input logic [31:0] lit,
                     input int lat);
    chk({nm, "_model"}, ref_res(o, x, y), lit);
    launch(o, x, y, r);
    wait_done(nm, lit, lat, r != 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    run("divu", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    chk("divu_addr", 32'(rd_addr), 32'd5);
    run("remu", OP_REMU, 32'd100, 32'd7, 5'd5, 32'd2, 34);
    run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6,
        32'hFFFF_FFFD, 34);
    run("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6,
        32'hFFFF_FFFF, 34);
    run("div0", OP_DIV, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
    run("rem0", OP_REM, 32'd5, 32'd0, 5'd7, 32'd5, 1);
    run("divu0", OP_DIVU, 32'd9, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,
        32'h8000_0000, 1);
    run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,
        32'd0, 1);
    run("mul", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10,
        32'd1, MUL_LAT);
    run("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11,
        32'hFFFF_FFFE, MUL_LAT);
    run("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd12,
        32'h4000_0000, MUL_LAT);
    run("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd13,
        32'hFFFF_FFFF, MUL_LAT);
    run("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd14,
        32'h0FFF_FFFF, 34);
    run("rem_negb", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd15,
        32'd1, 34);
    run("mul_rd0", OP_MUL, 32'd3, 32'hFFFF_FFFB, 5'd0,
        32'hFFFF_FFF1, MUL_LAT);

    // start pulsed mid-operation must be ignored
    launch(OP_DIVU, 32'd1000, 32'd10, 5'd17);
    repeat (4) tick();
    op = OP_DIV; a = 32'd1; b = 32'd1; rd = 5'd18; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign_start", 32'd100, 34, 1'b1);
    chk("ign_addr", 32'(rd_addr), 32'd17);

    // flush in CALC: no completion, back to idle
    launch(OP_DIV, 32'd77, 32'd3, 5'd19);
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= done;
      tick();
    end
    chk("kill_no_done", 32'(seen), 32'd0);
    chk("kill_idle", 32'(busy), 32'd0);
    chk("kill_data", rd_data, 32'd100);

    // kill together with start in idle: no launch
    @(posedge clk);
    #2;
    op = OP_DIVU; a = 32'd9; b = 32'd3; rd = 5'd20;
    start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    chk("kstart_busy", 32'(busy), 32'd0);

    // kill on the DONE cycle blocks the write
    launch(OP_DIV, 32'd5, 32'd0, 5'd3);
    kill = 1'b1;
    @(negedge clk);
    chk("kdone_done", 32'(done), 32'd1);
    chk("kdone_wren", 32'(wren), 32'd0);
    tick();
    kill = 1'b0;

    // async reset mid-divide
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4);
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_wren", 32'(wren), 32'd0);
    chk("arst_addr", 32'(rd_addr), 32'd0);
    chk("arst_data", rd_data, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    run("post_rst", OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 34);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
